// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave responder.
// Pure declarations: no latency, no backpressure.
package spi_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_MAX_LEN = 32;
    localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN) + 1;

    // Word position of serial bit number cnt in a len-bit character.
    function automatic int unsigned bit_index(input int unsigned cnt,
                                              input int unsigned len,
                                              input logic        lsb);
        return lsb ? cnt : (len - 32'd1 - cnt);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus edge detector; level valid 2 clk after the pad, edges decoded from a third flop.
// No backpressure: free-running, the pad is sampled every cycle.
module spi_sync_edge #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= INIT;
            s2 <= INIT;
            s3 <= INIT;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_slave_responder.sv
// Oversampled SPI slave: deserialises MOSI into rx_data and serialises tx_hold onto MISO; rx_valid 1 clk after the last sampled edge.
// Backpressure: tx_valid is held off by tx_ready until the single holding register has moved into the shifter.
module spi_slave_responder #(
    parameter int  MAX_LEN  = spi_slave_pkg::DEF_MAX_LEN,
    parameter int  SS_W     = 8,
    parameter int  SS_INDEX = 0,
    localparam int LEN_W    = $clog2(MAX_LEN) + 1
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [SS_W-1:0]    ss,
    input  logic               sclk,
    input  logic               mosi,
    output logic               miso,
    input  logic               rx_neg,
    input  logic               tx_neg,
    input  logic               lsb,
    input  logic [LEN_W-1:0]   char_len,
    input  logic [MAX_LEN-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [MAX_LEN-1:0] rx_data,
    output logic               rx_valid,
    output logic               tx_underrun,
    output logic               frame_err
);

    import spi_slave_pkg::*;

    localparam int IDX_W = $clog2(MAX_LEN);

    state_t             state, state_nx;
    logic               ss_others_unused, ss_lvl_unused, sclk_lvl_unused;
    logic               mosi_rise_unused, mosi_fall_unused;
    logic               ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_s;
    logic               start, stop, smp, shf, done;
    logic               rxneg_q, txneg_q, lsb_q, lsb_sel, tx_full, pend_under;
    logic [LEN_W-1:0]   len_in, len_q, len_sel, bit_cnt, cnt_nx, tx_idx;
    logic [IDX_W-1:0]   first_idx, next_idx, rx_idx;
    logic [MAX_LEN-1:0] tx_hold, tx_word, load_word, rx_shift, rx_next, rx_mask;

    assign ss_others_unused = ^ss;

    spi_sync_edge #(.INIT(1'b1)) u_ss (
        .clk(PCLK), .rst(PRESET), .d(ss[SS_INDEX]),
        .q(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.INIT(1'b0)) u_sclk (
        .clk(PCLK), .rst(PRESET), .d(sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.INIT(1'b0)) u_mosi (
        .clk(PCLK), .rst(PRESET), .d(mosi),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nx;
    end

    // With split edges, a shift edge before the first sample of a character
    // would skip bit 0 that the master has not yet captured.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        stop     = 1'b0;
        smp      = 1'b0;
        shf      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nx = ACTIVE;
                    start    = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_nx = IDLE;
                    stop     = 1'b1;
                end else begin
                    smp = rxneg_q ? sclk_fall : sclk_rise;
                    shf = (txneg_q ? sclk_fall : sclk_rise) &&
                          !((rxneg_q != txneg_q) && (bit_cnt == '0));
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign tx_ready  = ~tx_full;
    assign len_in    = (char_len == '0) ? LEN_W'(MAX_LEN) : char_len;
    assign len_sel   = start ? len_in : len_q;
    assign lsb_sel   = start ? lsb : lsb_q;
    assign cnt_nx    = bit_cnt + 1'b1;
    assign done      = smp && (cnt_nx == len_q);
    assign load_word = tx_full ? tx_hold : '0;
    assign first_idx = IDX_W'(bit_index(32'd0, 32'(len_sel), lsb_sel));
    assign next_idx  = IDX_W'(bit_index(32'(tx_idx) + 32'd1, 32'(len_q), lsb_q));
    assign rx_idx    = IDX_W'(bit_index(32'(bit_cnt), 32'(len_q), lsb_q));
    assign rx_mask   = (int'(len_q) >= MAX_LEN) ? '1
                     : ((MAX_LEN'(1) << len_q) - MAX_LEN'(1));

    always_comb begin
        rx_next         = rx_shift;
        rx_next[rx_idx] = mosi_s;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            tx_hold     <= '0;
            tx_full     <= 1'b0;
            tx_word     <= '0;
            tx_idx      <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            len_q       <= '0;
            rxneg_q     <= 1'b0;
            txneg_q     <= 1'b0;
            lsb_q       <= 1'b0;
            pend_under  <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            if (tx_valid && tx_ready) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end

            if (start) begin
                len_q       <= len_in;
                rxneg_q     <= rx_neg;
                txneg_q     <= tx_neg;
                lsb_q       <= lsb;
                bit_cnt     <= '0;
                tx_idx      <= '0;
                pend_under  <= 1'b0;
                tx_word     <= load_word;
                miso        <= load_word[first_idx];
                tx_underrun <= ~tx_full;
                if (tx_full) tx_full <= 1'b0;
            end else if (stop) begin
                frame_err  <= (bit_cnt != '0);
                bit_cnt    <= '0;
                pend_under <= 1'b0;
                miso       <= 1'b0;
            end else begin
                if (smp) begin
                    rx_shift <= rx_next;
                    // An empty reload only counts as underrun once the next
                    // character actually begins; a frame may simply end here.
                    if ((bit_cnt == '0) && pend_under) begin
                        tx_underrun <= 1'b1;
                        pend_under  <= 1'b0;
                    end
                    if (done) begin
                        rx_data  <= rx_next & rx_mask;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        tx_idx   <= '0;
                        tx_word  <= load_word;
                        miso     <= load_word[first_idx];
                        if (tx_full) tx_full    <= 1'b0;
                        else         pend_under <= 1'b1;
                    end else begin
                        bit_cnt <= cnt_nx;
                    end
                end
                if (shf && !done) begin
                    tx_idx <= tx_idx + 1'b1;
                    miso   <= tx_word[next_idx];
                end
            end
        end
    end

endmodule
